// File: rtl/mem_block_responder.sv
// mem_block_responder: refill responder that streams one aligned block from its
// word array after a fixed latency, with a preload write port usable only while idle.
module mem_block_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int BLK_WORDS = 4,
  parameter int LAT = 2,
  localparam int OFF_W = $clog2(BLK_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] blk_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [OFF_W-1:0]  raddr,
  output logic              END
);
  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;
  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] base_q;
  logic [OFF_W-1:0]  idx_q;
  logic              busy_q, rvalid_q, end_q;
  logic [DATA_W-1:0] rdata_q;
  logic [OFF_W-1:0]  raddr_q;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] rd_addr;
  assign rd_addr = base_q | ADDR_W'(idx_q);
  assign busy   = busy_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign raddr  = raddr_q;
  assign END    = end_q;
  always_ff @(posedge clk)
    if (wr_en && state_q == IDLE && !req) mem[wr_addr] <= wr_data;
  // BURST spends one extra cycle after the END word to drop rvalid before DONE
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      base_q   <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      end_q    <= 1'b0;
      rdata_q  <= '0;
      raddr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (req) begin
          base_q  <= blk_addr & ~ADDR_W'(BLK_WORDS - 1);
          busy_q  <= 1'b1;
          cnt_q   <= 4'(LAT);
          idx_q   <= '0;
          state_q <= (LAT == 0) ? BURST : WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= BURST;
        end
        BURST: if (end_q) begin
          rvalid_q <= 1'b0;
          end_q    <= 1'b0;
          state_q  <= DONE;
        end else begin
          rvalid_q <= 1'b1;
          rdata_q  <= mem[rd_addr];
          raddr_q  <= idx_q;
          end_q    <= idx_q == OFF_W'(BLK_WORDS - 1);
          idx_q    <= idx_q + 1'b1;
        end
        DONE: if (!req) begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_mem_block_responder.sv
// tb_mem_block_responder: drives a LAT=2 and a LAT=0 responder with shared stimulus and
// checks both against a cycle-indexed model plus hand-computed expectations.
module tb_mem_block_responder;
  logic        clk, rst_n, req, wr_en;
  logic [7:0]  blk_addr, wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  busy_w, rv_w, end_w;
  logic [31:0] rd_w [2];
  logic [1:0]  ra_w [2];
  int checks = 0, failures = 0;

  mem_block_responder #(.ADDR_W(8), .DATA_W(32), .BLK_WORDS(4), .LAT(2)) dut0 (
    .clk(clk), .reset(rst_n), .req(req), .blk_addr(blk_addr), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy_w[0]), .rvalid(rv_w[0]),
    .rdata(rd_w[0]), .raddr(ra_w[0]), .END(end_w[0]));
  mem_block_responder #(.ADDR_W(8), .DATA_W(32), .BLK_WORDS(4), .LAT(0)) dut1 (
    .clk(clk), .reset(rst_n), .req(req), .blk_addr(blk_addr), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy_w[1]), .rvalid(rv_w[1]),
    .rdata(rd_w[1]), .raddr(ra_w[1]), .END(end_w[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int latof(input int j);
    return (j == 0) ? 2 : 0;
  endfunction

  // model: k counts edges since acceptance; words at k=LAT+1..LAT+4, release from k=LAT+6
  bit          act [2];
  int          k [2];
  logic [7:0]  base [2];
  logic        mb [2], mv [2], me [2];
  logic [31:0] md [2];
  logic [1:0]  ma [2];
  logic [31:0] mm [2][256];

  always @(posedge clk or negedge rst_n) begin
    for (int j = 0; j < 2; j++) begin
      if (!rst_n) begin
        act[j] = 0; k[j] = 0; base[j] = '0;
        mb[j] = 0; mv[j] = 0; me[j] = 0; md[j] = '0; ma[j] = '0;
      end else if (!act[j]) begin
        if (!req && wr_en) mm[j][wr_addr] = wr_data;
        if (req) begin
          act[j] = 1; k[j] = 0; mb[j] = 1;
          base[j] = {blk_addr[7:2], 2'b00};
        end
      end else begin
        k[j]++;
        if (k[j] >= latof(j) + 1 && k[j] <= latof(j) + 4) begin
          ma[j] = 2'(k[j] - latof(j) - 1);
          md[j] = mm[j][base[j] | {6'd0, ma[j]}];
          mv[j] = 1;
          me[j] = (ma[j] == 2'd3);
        end else begin
          mv[j] = 0; me[j] = 0;
          if (k[j] >= latof(j) + 6 && !req) begin act[j] = 0; mb[j] = 0; end
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("busy%0d", j), busy_w[j], mb[j]);
      chk($sformatf("rvalid%0d", j), rv_w[j], mv[j]);
      chk($sformatf("end%0d", j), end_w[j], me[j]);
      chk($sformatf("rdata%0d", j), rd_w[j], md[j]);
      chk($sformatf("raddr%0d", j), ra_w[j], ma[j]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic burst_begin(input logic [7:0] a);
    blk_addr = a;
    req = 1'b1;
    tick();
  endtask

  task automatic drain();
    int n = 0;
    req = 1'b0;
    wr_en = 1'b0;
    while (busy_w != 2'b00 && n < 30) begin
      tick();
      n++;
    end
    chk("drain_timeout", busy_w, 2'b00);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; wr_en = 1'b0;
    blk_addr = '0; wr_addr = '0; wr_data = '0;
    tick(); tick();
    chk("rst_busy", busy_w, 2'b00);
    chk("rst_rvalid", rv_w, 2'b00);
    chk("rst_end", end_w, 2'b00);
    chk("rst_rdata", rd_w[0], 32'h0);
    chk("rst_raddr", ra_w[0], 2'd0);
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 256; a++) begin
      wr_en = 1'b1; wr_addr = 8'(a); wr_data = 32'h1000_0000 + 32'(a * 3);
      tick();
    end
    for (int a = 0; a < 4; a++) begin
      wr_addr = 8'(8 + a); wr_data = 32'hA0 + 32'(a);
      tick();
    end
    wr_en = 1'b0;
    tick();
    // basic block, address inside block
    burst_begin(8'd9);
    chk("t1_busy_e0", busy_w, 2'b11);
    tick();
    chk("t1_lat0_w0", rd_w[1], 32'hA0);
    chk("t1_lat0_rv", rv_w[1], 1'b1);
    tick(); tick();
    chk("t1_rv_e3", rv_w[0], 1'b1);
    chk("t1_rd_e3", rd_w[0], 32'hA0);
    chk("t1_ra_e3", ra_w[0], 2'd0);
    chk("t1_end_e3", end_w[0], 1'b0);
    tick();
    chk("t1_lat0_end", end_w, 2'b10);
    tick(); tick();
    chk("t1_rd_e6", rd_w[0], 32'hA3);
    chk("t1_ra_e6", ra_w[0], 2'd3);
    chk("t1_end_e6", end_w[0], 1'b1);
    drain();
    // top block on LAT=0, then req held high
    burst_begin(8'hFF);
    tick();
    chk("t2_rd_e1", rd_w[1], 32'h1000_02F4);
    chk("t2_ra_e1", ra_w[1], 2'd0);
    tick(); tick(); tick();
    chk("t2_rd_e4", rd_w[1], 32'h1000_02FD);
    chk("t2_end_e4", end_w[1], 1'b1);
    tick();
    req = 1'b0;
    tick();
    chk("t2_busy_e6", busy_w, 2'b01);
    req = 1'b1; blk_addr = 8'h40;
    tick();
    chk("t2_reaccept_e7", busy_w[1], 1'b1);
    repeat (14) tick();
    chk("t3_busy_held", busy_w, 2'b11);
    chk("t3_rv_held", rv_w, 2'b00);
    req = 1'b0;
    tick();
    chk("t3_release", busy_w, 2'b00);
    // req dropped early
    burst_begin(8'd8);
    tick();
    req = 1'b0;
    repeat (5) tick();
    chk("t4_end_e6", end_w[0], 1'b1);
    chk("t4_rd_e6", rd_w[0], 32'hA3);
    tick();
    chk("t4_busy_e7", busy_w[0], 1'b1);
    chk("t4_rv_e7", rv_w[0], 1'b0);
    tick();
    chk("t4_busy_e8", busy_w[0], 1'b0);
    drain();
    // async reset mid-burst
    burst_begin(8'h0A);
    repeat (4) tick();
    chk("t5_rd_e4", rd_w[0], 32'hA1);
    req = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("t5_busy", busy_w, 2'b00);
    chk("t5_rv", rv_w, 2'b00);
    chk("t5_end", end_w, 2'b00);
    chk("t5_rd", rd_w[0], 32'h0);
    chk("t5_ra", ra_w[0], 2'd0);
    #2 rst_n = 1'b1;
    tick();
    burst_begin(8'h0B);
    repeat (3) tick();
    chk("t5_rd_after", rd_w[0], 32'hA0);
    chk("t5_ra_after", ra_w[0], 2'd0);
    drain();
    // write while busy is ignored, write in idle lands
    burst_begin(8'h20);
    wr_en = 1'b1; wr_addr = 8'd9; wr_data = 32'hDEAD;
    repeat (3) tick();
    wr_en = 1'b0;
    drain();
    burst_begin(8'd8);
    repeat (4) tick();
    chk("t6_busy_wr", rd_w[0], 32'hA1);
    chk("t6_busy_ra", ra_w[0], 2'd1);
    drain();
    wr_en = 1'b1; wr_addr = 8'd9; wr_data = 32'hDEAD;
    tick();
    wr_en = 1'b0;
    burst_begin(8'd8);
    repeat (4) tick();
    chk("t6_idle_wr", rd_w[0], 32'hDEAD);
    chk("t6_idle_ra", ra_w[0], 2'd1);
    drain();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
